wb_write_queue: RTL and testbench
=================================

// Module: wb_write_queue
// PURPOSE
//   Write-back side of the decode-stage register file: buffers completed results
//   from the memory/write-back stage and replays them as one register write per
//   cycle on the regfile write port (reg_write / write_register / write_data).
//   Decouples pipeline completion bursts from the single regfile write port.
//   Drops writes to X31 (XZR).
// PARAMETERS
//   DEPTH      4      pending-write entries; power of two, >=2
//   ADDR_W     5      register index width (32 architectural registers)
// PORTS
//   clk             in   1          single clock; regfile write_clk is driven from it
//   reset           in   1          synchronous, active-high
//   in_valid        in   1          result available from write-back stage
//   in_ready        out  1          queue can accept (combinational: count < DEPTH)
//   in_rd           in   ADDR_W     destination register
//   in_data         in   `WORD      result value
//   hold            in   1          1 = do not issue a write this cycle
//   reg_write       out  1          regfile write enable (registered)
//   write_register  out  ADDR_W     regfile write address (registered)
//   write_data      out  `WORD      regfile write data (registered)
//   fwd_reg1/2      in   ADDR_W     decode read addresses to look up
//   fwd_hit1/2      out  1          pending write to fwd_regN exists
//   fwd_data1/2     out  `WORD      youngest pending value for fwd_regN
//   count           out  $clog2(DEPTH)+1  occupancy
// BEHAVIOUR
//   - Reset: count=0, rd/wr pointers=0, reg_write=0, write_register=0, write_data=0.
//     Reset mid-operation discards all pending entries; nothing is written.
//   - Push: on edge where in_valid && in_ready && in_rd != 31 -> tail <= {in_rd,in_data}.
//     in_valid && in_rd==31: accepted (handshake completes), not stored.
//   - in_ready = (count < DEPTH), from pre-edge count only; full queue refuses even if
//     a pop occurs in the same cycle.
//   - Pop: on edge where count != 0 (pre-edge) && !hold -> head loaded into
//     write_register/write_data, reg_write <= 1, rd pointer advances. Otherwise
//     reg_write <= 0; write_register/write_data hold their last value.
//   - Latency: entry pushed at edge N drives reg_write=1 after edge N+1 when queue was
//     empty and hold=0. Strict FIFO order; one write per cycle maximum.
//   - Simultaneous push and pop: both occur; count unchanged.
//   - Pointers wrap modulo DEPTH; count saturates nowhere (overflow impossible by in_ready).
//   - Empty + in_valid: no same-cycle bypass to the write port.
// CONFIGURATION
//   WB_FORWARD_EN defined: fwd_hitN/fwd_dataN combinational; search all valid queue
//     entries plus the output register while reg_write=1; youngest match wins (newest
//     queue entry > older entries > output register). fwd_regN==31 never hits.
//   WB_FORWARD_EN undefined: ports present, fwd_hitN=0, fwd_dataN=0; no search logic.
// STRUCTURE
//   - definitions.vh: `WORD, `XZR (31), `REG_ADDR_W (5); no new package.
//   - Sub-module wb_fifo: generic sync FIFO (DEPTH, WIDTH), exposes entry array and
//     valid mask for the forwarding search. Top keeps XZR filter, output regs, forward mux.
// TESTING
//   1. Reset then push {rd=3,data=0xA5} with hold=0 -> after next edge reg_write=1,
//      write_register=3, write_data=0xA5; following cycle reg_write=0.
//   2. hold=1, push 4 entries (rd 1..4) -> in_ready=0, count=4; 5th in_valid stalls;
//      release hold -> writes rd 1,2,3,4 on 4 consecutive cycles, in order.
//   3. Push rd=31 data=0xFF -> in_ready stays 1, count stays 0, reg_write never asserts.
//   4. hold=1, push rd=7 data=1 then rd=7 data=2 (WB_FORWARD_EN) -> fwd_reg1=7 gives
//      fwd_hit1=1, fwd_data1=2; fwd_reg2=31 gives fwd_hit2=0. Without macro: hits=0.
//   5. count=3, assert reset with in_valid=1 -> after edge count=0, reg_write=0,
//      in_ready=1; no queued writes issued afterwards.
//   6. count=4 (full), hold=0, in_valid=1 -> push refused that cycle, pop occurs,
//      count=3; push accepted next edge.

Source files
------------

// File: rtl/wb_write_queue_pkg.sv
// wb_write_queue_pkg
//   Shared definitions for the write-back queue slice.
//   Macros: `WORD_W (result width), `WORD (result range), `XZR (zero
//   register index), `REG_ADDR_W (register index width).
//   Package: WORD_W / XZR_IDX constants and the is_xzr() helper.
//   Compile this file first so the macros are visible to the other files.
`ifndef WB_DEFINITIONS_SV
`define WB_DEFINITIONS_SV
`define WORD_W 32
`define WORD [`WORD_W-1:0]
`define XZR 31
`define REG_ADDR_W 5
`endif

package wb_write_queue_pkg;
   localparam int WORD_W  = `WORD_W;
   localparam int XZR_IDX = `XZR;

   // Writes to the zero register are architecturally discarded.
   function automatic logic is_xzr(input int rd);
      return rd == XZR_IDX;
   endfunction
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo
//   Generic synchronous FIFO. Besides the normal head output it exposes the
//   whole storage array, a per-slot valid mask and the head pointer so a
//   parent can search pending entries in age order.
//   Ports:
//     clk, reset        clock, synchronous active-high reset (pointers/count)
//     push, wr_data     enqueue request (ignored when full)
//     pop               dequeue request (ignored when empty)
//     rd_data           current head entry
//     count             occupancy, 0..DEPTH
//     entries           flattened storage, slot i at [i*WIDTH +: WIDTH]
//     valid             slot i holds a pending entry
//     head_ptr          slot index of the oldest entry
module wb_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 37
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic [DEPTH*WIDTH-1:0]   entries,
   output logic [DEPTH-1:0]         valid,
   output logic [$clog2(DEPTH)-1:0] head_ptr
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;
   logic [PW-1:0]    off;

   assign do_push  = push && (count != CW'(DEPTH));
   assign do_pop   = pop && (count != '0);
   assign rd_data  = mem[rd_ptr];
   assign head_ptr = rd_ptr;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_flat
      assign entries[g*WIDTH +: WIDTH] = mem[g];
   end

   // A slot is live when its distance from the head is below the occupancy.
   always_comb begin
      valid = '0;
      off   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off      = PW'(i) - rd_ptr;
         valid[i] = CW'(off) < count;
      end
   end
endmodule

// File: rtl/wb_write_queue.sv
// wb_write_queue
//   Buffers completed results from the write-back stage and replays them as
//   at most one register-file write per cycle, in strict arrival order.
//   Results targeting the zero register are accepted but never stored.
//   Optional macro WB_FORWARD_EN: combinational lookup of the youngest
//   pending value (queue entries, then the output register) for two decode
//   read addresses. Without it the forward outputs are tied to zero.
//   Ports:
//     clk, reset                          clock, synchronous active-high reset
//     in_valid, in_ready, in_rd, in_data  result input handshake
//     hold                                suppress issuing a write this cycle
//     reg_write, write_register, write_data  registered regfile write port
//     fwd_reg1/2, fwd_hit1/2, fwd_data1/2    forwarding lookup
//     count                               queue occupancy
`ifndef WB_DEFINITIONS_SV
`define WB_DEFINITIONS_SV
`define WORD_W 32
`define WORD [`WORD_W-1:0]
`define XZR 31
`define REG_ADDR_W 5
`endif

module wb_write_queue
   import wb_write_queue_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = `REG_ADDR_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [ADDR_W-1:0]      in_rd,
   input  logic `WORD             in_data,
   input  logic                   hold,
   output logic                   reg_write,
   output logic [ADDR_W-1:0]      write_register,
   output logic `WORD             write_data,
   input  logic [ADDR_W-1:0]      fwd_reg1,
   input  logic [ADDR_W-1:0]      fwd_reg2,
   output logic                   fwd_hit1,
   output logic                   fwd_hit2,
   output logic `WORD             fwd_data1,
   output logic `WORD             fwd_data2,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PW    = $clog2(DEPTH);
   localparam int CW    = PW + 1;
   localparam int WIDTH = ADDR_W + WORD_W;

   logic                   push;
   logic                   pop;
   logic [WIDTH-1:0]       head;
   logic [DEPTH*WIDTH-1:0] q_entries;
   logic [DEPTH-1:0]       q_valid;
   logic [PW-1:0]          head_ptr;

   // Readiness looks only at the pre-edge count: a full queue refuses even
   // when a pop frees a slot on the same edge.
   assign in_ready = count < CW'(DEPTH);
   assign push     = in_valid && in_ready && !is_xzr(int'(in_rd));
   assign pop      = (count != '0) && !hold;

   wb_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .wr_data  ({in_rd, in_data}),
      .pop      (pop),
      .rd_data  (head),
      .count    (count),
      .entries  (q_entries),
      .valid    (q_valid),
      .head_ptr (head_ptr)
   );

   // Address/data keep their last value when no write issues.
   always_ff @(posedge clk) begin
      if (reset) begin
         reg_write      <= 1'b0;
         write_register <= '0;
         write_data     <= '0;
      end else begin
         reg_write <= pop;
         if (pop) begin
            write_register <= head[WIDTH-1 -: ADDR_W];
            write_data     <= head[WORD_W-1:0];
         end
      end
   end

`ifdef WB_FORWARD_EN
   // Scan oldest to youngest so later matches override earlier ones; the
   // output register is older than anything still queued.
   function automatic logic [WORD_W:0] lookup(input logic [ADDR_W-1:0] r);
      logic [WORD_W:0] res;
      logic [PW-1:0]   idx;
      logic [WIDTH-1:0] e;
      res = '0;
      idx = '0;
      e   = '0;
      if (!is_xzr(int'(r))) begin
         if (reg_write && write_register == r) res = {1'b1, write_data};
         for (int k = 0; k < DEPTH; k++) begin
            idx = head_ptr + PW'(k);
            e   = q_entries[int'(idx)*WIDTH +: WIDTH];
            if (q_valid[idx] && e[WIDTH-1 -: ADDR_W] == r) res = {1'b1, e[WORD_W-1:0]};
         end
      end
      return res;
   endfunction

   always_comb begin
      {fwd_hit1, fwd_data1} = lookup(fwd_reg1);
      {fwd_hit2, fwd_data2} = lookup(fwd_reg2);
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{fwd_reg1, fwd_reg2, q_entries, q_valid, head_ptr};
   assign fwd_hit1   = 1'b0;
   assign fwd_hit2   = 1'b0;
   assign fwd_data1  = '0;
   assign fwd_data2  = '0;
`endif
endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue
//   Directed bench for wb_write_queue. A queue-based model predicts every
//   output each cycle; literal expectations pin the key scenarios.
`ifndef WB_DEFINITIONS_SV
`define WB_DEFINITIONS_SV
`define WORD_W 32
`define WORD [`WORD_W-1:0]
`define XZR 31
`define REG_ADDR_W 5
`endif

module tb_wb_write_queue;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rd;
   logic [31:0] in_data;
   logic        hold;
   logic        reg_write;
   logic [4:0]  write_register;
   logic [31:0] write_data;
   logic [4:0]  fwd_reg1, fwd_reg2;
   logic        fwd_hit1, fwd_hit2;
   logic [31:0] fwd_data1, fwd_data2;
   logic [2:0]  count;

   wb_write_queue #(.DEPTH(DEPTH), .ADDR_W(5)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_rd(in_rd), .in_data(in_data), .hold(hold), .reg_write(reg_write),
      .write_register(write_register), .write_data(write_data),
      .fwd_reg1(fwd_reg1), .fwd_reg2(fwd_reg2), .fwd_hit1(fwd_hit1),
      .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
      .count(count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed { logic [4:0] rd; logic [31:0] d; } ent_t;
   ent_t        mq[$];
   logic        m_rw    = 1'b0;
   logic [4:0]  m_wreg  = '0;
   logic [31:0] m_wdata = '0;
   bit          m_pop, m_acc;
   ent_t        m_head;

   always @(posedge clk) begin
      if (reset) begin
         mq.delete();
         m_rw = 1'b0; m_wreg = '0; m_wdata = '0;
      end else begin
         m_pop = (mq.size() != 0) && !hold;
         m_acc = in_valid && (mq.size() < DEPTH);
         m_rw  = m_pop;
         if (m_pop) begin
            m_head  = mq.pop_front();
            m_wreg  = m_head.rd;
            m_wdata = m_head.d;
         end
         if (m_acc && in_rd != 5'd31) mq.push_back('{rd: in_rd, d: in_data});
      end
   end

   function automatic logic [32:0] m_fwd(input logic [4:0] r);
      logic [32:0] res = '0;
`ifdef WB_FORWARD_EN
      if (r != 5'd31) begin
         if (m_rw && m_wreg == r) res = {1'b1, m_wdata};
         foreach (mq[i]) if (mq[i].rd == r) res = {1'b1, mq[i].d};
      end
`endif
      return res;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", in_ready, mq.size() < DEPTH);
         chk("count", count, mq.size());
         chk("reg_write", reg_write, m_rw);
         chk("write_register", write_register, m_wreg);
         chk("write_data", write_data, m_wdata);
         chk("fwd1", {fwd_hit1, fwd_data1}, m_fwd(fwd_reg1));
         chk("fwd2", {fwd_hit2, fwd_data2}, m_fwd(fwd_reg2));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d);
      in_valid = v; in_rd = rd; in_data = d;
   endtask

   logic        exp_h;
   logic [31:0] exp_d;

   initial begin
      reset = 1'b1; hold = 1'b0; fwd_reg1 = '0; fwd_reg2 = '0;
      drive(1'b0, '0, '0);
      tick(); tick();
      chk_en = 1'b1;
      chk("rst_count", count, 0);
      chk("rst_reg_write", reg_write, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_wreg", write_register, 0);
      chk("rst_wdata", write_data, 0);
      reset = 1'b0;

      // single write, one-cycle latency
      drive(1'b1, 5'd3, 32'hA5);
      tick();
      drive(1'b0, '0, '0);
      chk("t1_count", count, 1);
      chk("t1_rw_early", reg_write, 0);
      tick();
      chk("t1_rw", reg_write, 1);
      chk("t1_wreg", write_register, 3);
      chk("t1_wdata", write_data, 32'hA5);
      tick();
      chk("t1_rw_off", reg_write, 0);

      // fill under hold, stall, then drain in order
      hold = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 5'(i), 32'h10 + 32'(i));
         tick();
      end
      chk("t2_full_count", count, 4);
      chk("t2_full_ready", in_ready, 0);
      drive(1'b1, 5'd5, 32'h55);
      tick();
      chk("t2_stall_count", count, 4);
      drive(1'b0, '0, '0);
      hold = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("t2_rw", reg_write, 1);
         chk("t2_wreg", write_register, 5'(i));
         chk("t2_wdata", write_data, 32'h10 + 32'(i));
      end
      tick();
      chk("t2_idle", reg_write, 0);

      // zero-register write is dropped
      drive(1'b1, 5'd31, 32'hFF);
      tick();
      chk("t3_ready", in_ready, 1);
      chk("t3_count", count, 0);
      drive(1'b0, '0, '0);
      tick();
      chk("t3_rw", reg_write, 0);

      // forwarding: youngest of two writes to r7; r31 never hits
      hold = 1'b1;
      drive(1'b1, 5'd7, 32'd1); tick();
      drive(1'b1, 5'd7, 32'd2); tick();
      drive(1'b1, 5'd9, 32'd3); tick();
      drive(1'b0, '0, '0);
      fwd_reg1 = 5'd7; fwd_reg2 = 5'd31;
      tick();
`ifdef WB_FORWARD_EN
      exp_h = 1'b1; exp_d = 32'd2;
`else
      exp_h = 1'b0; exp_d = 32'd0;
`endif
      chk("t4_hit1", fwd_hit1, exp_h);
      chk("t4_data1", fwd_data1, exp_d);
      chk("t4_hit2", fwd_hit2, 0);
      chk("t4_count", count, 3);

      // reset with three pending entries and in_valid high
      reset = 1'b1;
      drive(1'b1, 5'd6, 32'h66);
      tick();
      reset = 1'b0; hold = 1'b0;
      drive(1'b0, '0, '0);
      chk("t5_count", count, 0);
      chk("t5_rw", reg_write, 0);
      chk("t5_ready", in_ready, 1);
      tick(); tick(); tick();
      chk("t5_no_write", reg_write, 0);

      // full queue refuses while popping, accepts next edge
      hold = 1'b1;
      for (int i = 10; i <= 13; i++) begin
         drive(1'b1, 5'(i), 32'(i) * 32'h100);
         tick();
      end
      drive(1'b1, 5'd14, 32'hE);
      hold = 1'b0;
      tick();
      chk("t6_refuse_count", count, 3);
      chk("t6_wreg0", write_register, 10);
      tick();
      chk("t6_accept_count", count, 3);
      chk("t6_wreg1", write_register, 11);
      drive(1'b0, '0, '0);
      fwd_reg1 = 5'd14; fwd_reg2 = 5'd12;
      for (int i = 0; i < 5; i++) tick();
      chk("t6_drained", count, 0);
      chk("t6_last_wdata", write_data, 32'hE);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
